// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, address to InstructionMemory, IF/ID capture.
// Latency: word addressed in cycle n-1 is in IF/ID after edge n; redirect costs 1 bubble.
// Backpressure: stall holds PC and IF/ID; flush and branch insert a bubble.
//
// Ports: clk/rst (sync, active-high); stall, flush, branch_taken, branch_target
// in; instruccion from memory; direccion (= PC) out; if_id_instr/_pc/_pc_plus4/
// _valid pipeline register; misaligned one-cycle redirect flag; fetch_count
// saturating count of valid captures; halted.
// Optional feature macro FETCH_HALT_EN: an all-ones word halts fetch until a
// branch or reset. Without it, halted is tied to 0.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] PC_STEP  = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [7:0]  branch_target,
  input  logic [31:0] instruccion,
  output logic [7:0]  direccion,
  output logic [31:0] if_id_instr,
  output logic [7:0]  if_id_pc,
  output logic [7:0]  if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        misaligned,
  output logic [15:0] fetch_count,
  output logic        halted
);

  logic [7:0]  pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  ipc_q, ipc_d;
  logic [7:0]  ipc4_q, ipc4_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  pc_seq;
  logic        halt_active;

`ifdef FETCH_HALT_EN
  logic halt_q, halt_d;
  assign halt_active = halt_q;
`else
  assign halt_active = 1'b0;
`endif

  // Sequential next address; 8-bit wrap is intentional and unflagged.
  assign pc_seq = pc_q + PC_STEP;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    mis_d   = 1'b0;
    cnt_d   = cnt_q;
`ifdef FETCH_HALT_EN
    halt_d  = halt_q;
`endif
    if (branch_taken) begin
      // Target is forced word-aligned; the low bits only raise the flag.
      pc_d    = {branch_target[7:2], 2'b00};
      valid_d = 1'b0;
      mis_d   = |branch_target[1:0];
`ifdef FETCH_HALT_EN
      halt_d  = 1'b0;
`endif
    end else if (halt_active) begin
      // PC frozen; keep emitting bubbles until a redirect or reset.
      valid_d = 1'b0;
    end else if (flush) begin
      valid_d = 1'b0;
      if (!stall) pc_d = pc_seq;
    end else if (!stall) begin
      instr_d = instruccion;
      ipc_d   = pc_q;
      ipc4_d  = pc_seq;
      valid_d = 1'b1;
      pc_d    = pc_seq;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`ifdef FETCH_HALT_EN
      halt_d  = (instruccion == 32'hFFFF_FFFF);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      ipc_q   <= 8'h0;
      ipc4_q  <= 8'h0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= 16'h0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end
`endif

  assign direccion      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ipc_q;
  assign if_id_pc_plus4 = ipc4_q;
  assign if_id_valid    = valid_q;
  assign misaligned     = mis_q;
  assign fetch_count    = cnt_q;
  assign halted         = halt_active;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of `InstructionMemory`. Holds the program counter, drives the 8-bit byte address `direccion` to the memory, and captures the returned 32-bit `instruccion` into the IF/ID pipeline register for the decoder. Supports pipeline stall, flush, and taken-branch redirect, and keeps a saturating count of fetched instructions.

## Interface
Parameters:
- `RESET_PC`, default 8'h00: PC value after reset.
- `PC_STEP`, default 8'd4: byte increment per sequential fetch.

Ports:
- Clock and reset: one clock (`clk`); reset (`rst`) is synchronous and active-high.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset.
- `stall`  in  1  hold PC and IF/ID.
- `flush`  in  1  invalidate IF/ID next edge.
- `branch_taken`  in  1  redirect PC.
- `branch_target`  in  8  redirect byte address.
- `instruccion`  in  32  word returned by `InstructionMemory` (combinational read).
- `direccion`  out  8  current PC, to `InstructionMemory`.
- `if_id_instr`  out  32  registered instruction.
- `if_id_pc`  out  8  address of `if_id_instr`.
- `if_id_pc_plus4`  out  8  `if_id_pc + PC_STEP`, mod 256.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `misaligned`  out  1  registered, set for one cycle when `branch_target[1:0] != 0`.
- `fetch_count`  out  16  valid captures, saturating.
- `halted`  out  1  see Configuration.

## Operation
- `direccion` = PC register, driven combinationally. No other logic is in the address path.
- Per-edge priority: `rst` > `branch_taken` > `flush` > `stall` > normal.
- **Reset:**
  - PC = `RESET_PC`.
  - `if_id_instr`, `if_id_pc`, and `if_id_pc_plus4` are 0.
  - `if_id_valid`, `misaligned`, and `halted` are 0.
  - `fetch_count` = 0.
- **branch_taken:**
  - PC ← {`branch_target[7:2]`, 2'b00}.
  - `if_id_valid` ← 0, giving a bubble.
  - `misaligned` ← |`branch_target[1:0]`.
  - Overrides `stall` and `flush`.
- **flush without branch:**
  - `if_id_valid` ← 0.
  - PC ← PC + `PC_STEP`, unless `stall` is also high, in which case PC holds.
- **stall:**
  - PC and all IF/ID fields hold.
  - `fetch_count` holds.
- **Normal:**
  - `if_id_instr` ← `instruccion`.
  - `if_id_pc` ← PC.
  - `if_id_pc_plus4` ← PC + `PC_STEP`.
  - `if_id_valid` ← 1.
  - PC ← PC + `PC_STEP`.
- **PC arithmetic:** 8-bit, wraps modulo 256. Address 252 + 4 → 0, and the wrap sets no flag.
- **Counter:** `fetch_count` increments on every edge that writes `if_id_valid` = 1. It saturates at 16'hFFFF.
- **misaligned:** cleared on every edge without `branch_taken`.

## Timing
- Edge n captures the word addressed by the PC during cycle n−1. Fetch-to-IF/ID latency is 1 cycle.
- Redirect penalty is 1 bubble:
  - `branch_taken` sampled at edge n.
  - Target word is valid in IF/ID after edge n+1.
- Stall is sampled each edge. Deasserting it resumes the sequence with no lost or duplicated fetch.
- `rst` asserted mid-stall or mid-redirect wins fully on that edge.

## Configuration
- Macro: `FETCH_HALT_EN`.
- **Defined:**
  - On a normal capture of `instruccion` == 32'hFFFFFFFF, the word is captured with `if_id_valid` = 1 and `halted` ← 1.
  - While halted, PC freezes and each subsequent edge writes `if_id_valid` ← 0. `fetch_count` holds.
  - `branch_taken` clears `halted` and redirects normally, because the halt word was on the wrong path.
  - `rst` clears `halted`.
- **Undefined:**
  - `halted` is tied to 0.
  - 32'hFFFFFFFF is fetched like any other word.

## Test plan
- Reset sequence, then 5 free-running cycles with no stall → `direccion` = 0, 4, 8, 12, 16. Each IF/ID capture has `if_id_pc_plus4` = `if_id_pc` + 4, and `fetch_count` = 5.
- `stall` held 3 cycles starting at PC = 8 → `direccion` stays 8, IF/ID holds its word, and `fetch_count` holds. After release, next `if_id_pc` = 8.
- `branch_taken` with `branch_target` = 8'h41 while `stall` = 1:
  - Next cycle: PC = 8'h40, `if_id_valid` = 0, `misaligned` = 1.
  - Following cycle: `if_id_pc` = 8'h40, `misaligned` = 0.
- PC started at 248 via branch → sequence 248, 252, 0, 4 with no flag set. `rst` asserted at PC = 4 with `stall` = 1 → PC = 0 and `if_id_valid` = 0 on the next edge.
- `flush` alone at PC = 20 → `if_id_valid` = 0 and PC = 24 next edge.
- With `FETCH_HALT_EN`, memory word 32'hFFFFFFFF at address 12:
  - `halted` = 1 after the capture of address 12, and `direccion` stays at 16.
  - A subsequent `branch_taken` to 8'h00 clears `halted` and resumes fetch at 0.
  - Without `FETCH_HALT_EN`, the same stimulus never sets `halted`.
